mat_add_seq: RTL and testbench

Sequencer that streams a rows×cols matrix pair from two on-chip operand buffers into the saturating element-wise adder and writes the adder's result stream into a third buffer. It sits between the residual/skip-connection buffers and the adder. It generates row-major read addresses, per-row `tlast`, and result write addresses, and absorbs read latency and adder backpressure with credit-controlled operand FIFOs. One `start` runs one full matrix; `done` pulses on completion.

---
 rtl/mat_add_seq.sv | 243 ++++++++++++++++++++++++
 tb/tb_mat_add_seq.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mat_add_seq.sv
// mat_add_seq: streams a rows x cols matrix pair out of two operand buffers
// into a saturating element-wise adder, and writes the adder's result stream
// into a third buffer. Generates row-major read/write addresses and per-row
// tlast. Absorbs buffer read latency and adder backpressure with two
// credit-controlled 4-entry operand FIFOs.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   start, rows, cols             launch + dimensions (latched on start in IDLE)
//   base_r, base_y, base_z        buffer base addresses (latched on start)
//   busy, done, err               status: not-idle, completion pulse, sticky tlast error
//   rd_en, rd_addr_r, rd_addr_y   operand buffer read port (data one cycle later)
//   rd_data_r, rd_data_y          operand read data
//   r_t*, y_t*                    operand streams to the adder
//   z_t*                          result stream from the adder
//   wr_en, wr_addr, wr_data       result buffer write port

// Small 4-entry FIFO holding operand data plus its tlast bit.
module mat_add_seq_fifo #(
    parameter int D_W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           push,
    input  logic [D_W-1:0] push_data,
    input  logic           push_last,
    input  logic           tready,
    output logic           tvalid,
    output logic [D_W-1:0] tdata,
    output logic           tlast,
    output logic [2:0]     count
);
    logic [D_W-1:0] mem [4];
    logic [3:0]     last_mem;
    logic [1:0]     wp;
    logic [1:0]     rp;
    logic           pop;

    assign tvalid = (count != 3'd0);
    assign pop    = tvalid & tready;
    assign tdata  = tvalid ? mem[rp] : '0;
    assign tlast  = tvalid & last_mem[rp];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                mem[i] <= '0;
            end
            last_mem <= '0;
            wp       <= '0;
            rp       <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                mem[wp]      <= push_data;
                last_mem[wp] <= push_last;
                wp           <= wp + 2'd1;
            end
            if (pop) begin
                rp <= rp + 2'd1;
            end
            case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: ;
            endcase
        end
    end
endmodule

// Sequencer FSM
//   state   | meaning
//   S_IDLE  | waiting for start; dimensions and bases latched on start
//   S_RUN   | issuing operand reads (credit-limited), accepting results
//   S_DRAIN | all reads issued, accepting remaining results
//   S_DONE  | one-cycle completion pulse, then back to IDLE
module mat_add_seq #(
    parameter int D_W    = 8,
    parameter int ADDR_W = 12,
    parameter int DIM_W  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DIM_W-1:0]  rows,
    input  logic [DIM_W-1:0]  cols,
    input  logic [ADDR_W-1:0] base_r,
    input  logic [ADDR_W-1:0] base_y,
    input  logic [ADDR_W-1:0] base_z,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr_r,
    output logic [ADDR_W-1:0] rd_addr_y,
    input  logic [D_W-1:0]    rd_data_r,
    input  logic [D_W-1:0]    rd_data_y,
    output logic              r_tvalid,
    input  logic              r_tready,
    output logic [D_W-1:0]    r_tdata,
    output logic              r_tlast,
    output logic              y_tvalid,
    input  logic              y_tready,
    output logic [D_W-1:0]    y_tdata,
    output logic              y_tlast,
    input  logic              z_tvalid,
    output logic              z_tready,
    input  logic [D_W-1:0]    z_tdata,
    input  logic              z_tlast,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [D_W-1:0]    wr_data
);
    localparam int N_W = 2 * DIM_W;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t            state;
    state_t            state_nx;
    logic [DIM_W-1:0]  cols_q;
    logic [DIM_W-1:0]  cols_m1;
    logic [N_W-1:0]    iss_left;
    logic [N_W-1:0]    out_left;
    logic [DIM_W-1:0]  iss_col;
    logic [DIM_W-1:0]  out_col;
    logic [ADDR_W-1:0] ptr_r;
    logic [ADDR_W-1:0] ptr_y;
    logic [ADDR_W-1:0] ptr_z;
    logic              rd_q;
    logic              rd_last_q;
    logic              err_q;
    logic [2:0]        r_cnt;
    logic [2:0]        y_cnt;
    logic              start_ok;
    logic              dims_zero;
    logic              z_hs;
    logic              exp_zlast;

    assign cols_m1   = cols_q - DIM_W'(1);
    assign start_ok  = (state == S_IDLE) && start;
    assign dims_zero = (rows == '0) || (cols == '0);
    assign z_tready  = (state == S_RUN) || (state == S_DRAIN);
    assign z_hs      = z_tvalid && z_tready;
    assign exp_zlast = (out_col == cols_m1);

    // Credit check: FIFO occupancy plus the read still in flight must leave
    // room, so a returning read can always be pushed.
    assign rd_en = (state == S_RUN) && (iss_left != '0) &&
                   ((r_cnt + {2'b00, rd_q}) < 3'd4) &&
                   ((y_cnt + {2'b00, rd_q}) < 3'd4);

    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign err       = err_q;
    assign rd_addr_r = ptr_r;
    assign rd_addr_y = ptr_y;
    assign wr_en     = z_hs;
    assign wr_addr   = ptr_z;
    assign wr_data   = z_hs ? z_tdata : '0;

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = dims_zero ? S_DONE : S_RUN;
            S_RUN:   if (rd_en && (iss_left == N_W'(1))) state_nx = S_DRAIN;
            S_DRAIN: if (z_hs && (out_left == N_W'(1))) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cols_q    <= '0;
            iss_left  <= '0;
            out_left  <= '0;
            iss_col   <= '0;
            out_col   <= '0;
            ptr_r     <= '0;
            ptr_y     <= '0;
            ptr_z     <= '0;
            rd_q      <= 1'b0;
            rd_last_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state     <= state_nx;
            rd_q      <= rd_en;
            rd_last_q <= rd_en && (iss_col == cols_m1);
            if (start_ok) begin
                cols_q   <= cols;
                iss_left <= N_W'(rows) * N_W'(cols);
                out_left <= N_W'(rows) * N_W'(cols);
                iss_col  <= '0;
                out_col  <= '0;
                ptr_r    <= base_r;
                ptr_y    <= base_y;
                ptr_z    <= base_z;
                err_q    <= 1'b0;
            end
            if (rd_en) begin
                ptr_r    <= ptr_r + ADDR_W'(1);
                ptr_y    <= ptr_y + ADDR_W'(1);
                iss_left <= iss_left - N_W'(1);
                iss_col  <= (iss_col == cols_m1) ? '0 : iss_col + DIM_W'(1);
            end
            if (z_hs) begin
                ptr_z    <= ptr_z + ADDR_W'(1);
                out_left <= out_left - N_W'(1);
                out_col  <= (out_col == cols_m1) ? '0 : out_col + DIM_W'(1);
                if (z_tlast != exp_zlast) begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    mat_add_seq_fifo #(.D_W(D_W)) u_fifo_r (
        .clk       (clk),
        .rst       (rst),
        .push      (rd_q),
        .push_data (rd_data_r),
        .push_last (rd_last_q),
        .tready    (r_tready),
        .tvalid    (r_tvalid),
        .tdata     (r_tdata),
        .tlast     (r_tlast),
        .count     (r_cnt)
    );

    mat_add_seq_fifo #(.D_W(D_W)) u_fifo_y (
        .clk       (clk),
        .rst       (rst),
        .push      (rd_q),
        .push_data (rd_data_y),
        .push_last (rd_last_q),
        .tready    (y_tready),
        .tvalid    (y_tvalid),
        .tdata     (y_tdata),
        .tlast     (y_tlast),
        .count     (y_cnt)
    );
endmodule

// File: tb/tb_mat_add_seq.sv
// Bench for mat_add_seq: buffer and adder models around the DUT, expected
// reads/operands/writes queued at launch, checked by a monitor on handshakes.
module tb_mat_add_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [9:0]  rows = '0;
    logic [9:0]  cols = '0;
    logic [11:0] base_r = '0;
    logic [11:0] base_y = '0;
    logic [11:0] base_z = '0;
    logic        busy, done, err, rd_en, wr_en;
    logic [11:0] rd_addr_r, rd_addr_y, wr_addr;
    logic [7:0]  rd_data_r = '0;
    logic [7:0]  rd_data_y = '0;
    logic        r_tvalid, r_tlast, y_tvalid, y_tlast, z_tready;
    logic        r_tready = 1'b1;
    logic        y_tready = 1'b1;
    logic [7:0]  r_tdata, y_tdata, wr_data;
    logic        z_tvalid = 1'b0;
    logic [7:0]  z_tdata = '0;
    logic        z_tlast = 1'b0;

    mat_add_seq dut (
        .clk(clk), .rst(rst), .start(start), .rows(rows), .cols(cols),
        .base_r(base_r), .base_y(base_y), .base_z(base_z),
        .busy(busy), .done(done), .err(err),
        .rd_en(rd_en), .rd_addr_r(rd_addr_r), .rd_addr_y(rd_addr_y),
        .rd_data_r(rd_data_r), .rd_data_y(rd_data_y),
        .r_tvalid(r_tvalid), .r_tready(r_tready), .r_tdata(r_tdata), .r_tlast(r_tlast),
        .y_tvalid(y_tvalid), .y_tready(y_tready), .y_tdata(y_tdata), .y_tlast(y_tlast),
        .z_tvalid(z_tvalid), .z_tready(z_tready), .z_tdata(z_tdata), .z_tlast(z_tlast),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    logic [7:0] mem_r [0:4095];
    logic [7:0] mem_y [0:4095];

    typedef struct {
        logic [7:0] d;
        logic       last;
        int         rdy;
        int         idx;
    } zent_t;

    logic [23:0] exp_rd[$];
    logic [8:0]  exp_r[$];
    logic [8:0]  exp_y[$];
    logic [19:0] exp_wr[$];
    logic [8:0]  rq[$];
    logic [8:0]  yq[$];
    zent_t       outq[$];

    int bad_idx = -1;
    int pair_idx = 0;
    int rd_iss = 0, r_pop = 0, y_pop = 0;
    int rd_cnt = 0, wr_cnt = 0;
    int first_rd = -1, first_rv = -1, last_z = -1;
    int run_s = 0;
    logic       rd_pend = 1'b0;
    logic [7:0] pend_r = '0, pend_y = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string nm);
        total++;
        bad++;
        $display("FAIL %s: got unexpected event expected none (cycle %0d)", nm, cyc);
    endtask

    function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
        int s;
        s = int'($signed(a)) + int'($signed(b));
        if (s > 127) s = 127;
        if (s < -128) s = -128;
        return 8'(s);
    endfunction

    // Monitor + buffer read model + adder model (2-cycle latency).
    always begin
        @(negedge clk);
        if (rst) begin
            rq.delete();
            yq.delete();
            outq.delete();
            rd_pend = 1'b0;
        end else begin
            if (rd_en) begin
                rd_cnt++;
                if (first_rd < 0) first_rd = cyc;
                chk("outstanding_r", ((rd_iss - r_pop) < 4), 1);
                chk("outstanding_y", ((rd_iss - y_pop) < 4), 1);
                if (exp_rd.size() == 0) fail_now("rd_unexpected");
                else begin
                    logic [23:0] e;
                    e = exp_rd.pop_front();
                    chk("rd_addr_r", rd_addr_r, e[23:12]);
                    chk("rd_addr_y", rd_addr_y, e[11:0]);
                end
                rd_iss++;
            end
            rd_pend = rd_en;
            pend_r  = mem_r[rd_addr_r];
            pend_y  = mem_y[rd_addr_y];
            if (r_tvalid && first_rv < 0) first_rv = cyc;
            if (r_tvalid && r_tready) begin
                r_pop++;
                if (exp_r.size() == 0) fail_now("r_unexpected");
                else chk("r_stream", {r_tlast, r_tdata}, exp_r.pop_front());
                rq.push_back({r_tlast, r_tdata});
            end
            if (y_tvalid && y_tready) begin
                y_pop++;
                if (exp_y.size() == 0) fail_now("y_unexpected");
                else chk("y_stream", {y_tlast, y_tdata}, exp_y.pop_front());
                yq.push_back({y_tlast, y_tdata});
            end
            while (rq.size() > 0 && yq.size() > 0) begin
                logic [8:0] a, b;
                zent_t ze;
                a = rq.pop_front();
                b = yq.pop_front();
                ze.d = sat_add(a[7:0], b[7:0]);
                ze.last = a[8];
                ze.rdy = cyc + 2;
                ze.idx = pair_idx;
                pair_idx++;
                outq.push_back(ze);
            end
            if (z_tvalid && z_tready) begin
                void'(outq.pop_front());
                last_z = cyc;
            end
            if (wr_en) begin
                wr_cnt++;
                if (exp_wr.size() == 0) fail_now("wr_unexpected");
                else chk("wr_addr_data", {wr_addr, wr_data}, exp_wr.pop_front());
            end
        end
        @(posedge clk);
        #1;
        rd_data_r = rd_pend ? pend_r : 8'h00;
        rd_data_y = rd_pend ? pend_y : 8'h00;
        if (outq.size() > 0 && outq[0].rdy <= cyc) begin
            z_tvalid = 1'b1;
            z_tdata  = outq[0].d;
            z_tlast  = (outq[0].idx == bad_idx) ? 1'b1 : outq[0].last;
        end else begin
            z_tvalid = 1'b0;
            z_tdata  = 8'h00;
            z_tlast  = 1'b0;
        end
    end

    task automatic chk_reset_vals();
        chk("rst_ctl", {busy, done, err, rd_en, wr_en, r_tvalid, y_tvalid, r_tlast, y_tlast, z_tready}, 0);
        chk("rst_addr", {rd_addr_r, rd_addr_y, wr_addr}, 0);
        chk("rst_data", {wr_data, r_tdata, y_tdata}, 0);
    endtask

    // Fill buffers and queue the expected behaviour of one matrix.
    task automatic prep(input int nr, input int nc, input int br, input int by, input int bz,
                        input int patt);
        int n;
        n = nr * nc;
        for (int i = 0; i < n; i++) begin
            int ar, ay, az;
            logic [7:0] vr, vy;
            logic lst;
            ar = (br + i) % 4096;
            ay = (by + i) % 4096;
            az = (bz + i) % 4096;
            vr = patt ? 8'(i) : 8'($urandom_range(0, 255));
            vy = patt ? 8'(10 * i) : 8'($urandom_range(0, 255));
            mem_r[ar] = vr;
            mem_y[ay] = vy;
            lst = ((i % nc) == nc - 1);
            exp_rd.push_back({12'(ar), 12'(ay)});
            exp_r.push_back({lst, vr});
            exp_y.push_back({lst, vy});
            exp_wr.push_back({12'(az), sat_add(vr, vy)});
        end
        pair_idx = 0;
        rd_iss = 0; r_pop = 0; y_pop = 0;
        rd_cnt = 0; wr_cnt = 0;
        first_rd = -1; first_rv = -1; last_z = -1;
    endtask

    task automatic kick(input int nr, input int nc, input int br, input int by, input int bz);
        @(posedge clk);
        #2;
        start = 1'b1;
        rows = 10'(nr);
        cols = 10'(nc);
        base_r = 12'(br);
        base_y = 12'(by);
        base_z = 12'(bz);
        run_s = cyc;
    endtask

    // mode 0: tready high, 1: r_tready low for cycles 3..10, 2: random tready
    task automatic run_mat(input int nr, input int nc, input int br, input int by, input int bz,
                           input int patt, input int bidx, input int exp_err, input int mode);
        int n, rel, done_rel;
        n = nr * nc;
        done_rel = -1;
        bad_idx = bidx;
        prep(nr, nc, br, by, bz, patt);
        kick(nr, nc, br, by, bz);
        for (int k = 0; k < 400; k++) begin
            @(posedge clk);
            #2;
            start = 1'b0;
            rel = cyc - run_s;
            if (mode == 1) begin
                r_tready = !(rel >= 3 && rel <= 10);
                y_tready = 1'b1;
            end else if (mode == 2) begin
                r_tready = 1'($urandom_range(0, 1));
                y_tready = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            if (rel == 1) begin
                chk("busy_at_cycle1", busy, 1);
                chk("err_cleared_by_start", err, 0);
            end
            if (done) begin
                done_rel = rel;
                break;
            end
        end
        r_tready = 1'b1;
        y_tready = 1'b1;
        if (done_rel < 0) begin
            fail_now("done_timeout");
        end else if (n == 0) begin
            chk("done_cycle_zero_dims", done_rel, 1);
        end else begin
            chk("done_after_last_z", done_rel, last_z - run_s + 1);
        end
        chk("rd_count", rd_cnt, n);
        chk("wr_count", wr_cnt, n);
        chk("exp_left", exp_rd.size() + exp_r.size() + exp_y.size() + exp_wr.size(), 0);
        chk("err_at_done", err, exp_err);
        @(posedge clk);
        #2;
        @(negedge clk);
        chk("idle_after_done", {busy, done}, 0);
        chk("err_sticky", err, exp_err);
        bad_idx = -1;
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_vals();
        @(posedge clk);
        #2;
        rst = 1'b0;

        // 2x3 reference pattern, free-flowing streams
        run_mat(2, 3, 'h010, 'h020, 'h030, 1, -1, 0, 0);
        chk("first_rd_cycle", first_rd - run_s, 1);
        chk("first_rvalid_cycle", first_rv - run_s, 3);

        // same matrix with R held off for cycles 3..10
        run_mat(2, 3, 'h010, 'h020, 'h030, 1, -1, 0, 1);

        // zero dimension: straight to DONE
        run_mat(0, 5, 'h100, 'h200, 'h300, 0, -1, 0, 0);

        // read address wrap
        run_mat(1, 4, 'hFFE, 'h040, 'h050, 0, -1, 0, 0);

        // bad tlast on element 1, then a clean run clears err
        run_mat(1, 4, 'h060, 'h070, 'h080, 0, 1, 1, 0);
        run_mat(1, 3, 'h090, 'h0A0, 'h0B0, 0, -1, 0, 0);

        // reset in the middle of a 4x4 run
        bad_idx = -1;
        prep(4, 4, 'h200, 'h300, 'h400, 0);
        kick(4, 4, 'h200, 'h300, 'h400);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #2;
            start = 1'b0;
        end
        rst = 1'b1;
        exp_rd.delete();
        exp_r.delete();
        exp_y.delete();
        exp_wr.delete();
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        chk_reset_vals();
        run_mat(4, 4, 'h200, 'h300, 'h400, 0, -1, 0, 0);

        // randomized matrices with random backpressure
        for (int t = 0; t < 6; t++) begin
            run_mat(int'($urandom_range(1, 5)), int'($urandom_range(1, 5)),
                    int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)),
                    int'($urandom_range(0, 4095)), 0, -1, 0, 2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
